// File: rtl/timed_decoder_pkg.sv
// rtl/timed_decoder_pkg.sv - shared state type and default timing constants for the pulse decoder
package timed_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int unsigned DEF_T_GLITCH = 4;
  localparam int unsigned DEF_T_DASH   = 60;
  localparam int unsigned DEF_T_LETTER = 120;
  localparam int unsigned DEF_TW       = 16;
  localparam int unsigned MAX_ELEMS    = 5;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/timed_pulse_decoder.sv
// rtl/timed_pulse_decoder.sv - classifies on/off-keyed marks into dots and dashes and emits one symbol per letter gap
module timed_pulse_decoder
  import timed_decoder_pkg::*;
#(
  parameter int unsigned T_GLITCH = DEF_T_GLITCH,
  parameter int unsigned T_DASH   = DEF_T_DASH,
  parameter int unsigned T_LETTER = DEF_T_LETTER,
  parameter int unsigned TW       = DEF_TW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic [4:0] code,
  output logic [2:0] len,
  output logic       valid,
  output logic       err
);

  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] t;
  logic [TW:0]   mark_len;
  logic          sig_s;
  logic          push;
  logic          push_bit;
  logic          emit;
  logic [4:0]    sr;
  logic [2:0]    count;
  logic          err_int;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .q     (sig_s)
  );

  // One extra bit so a saturated timer still yields a length above T_DASH.
  assign mark_len = {1'b0, t} + (TW+1)'(1);
  assign push_bit = (mark_len >= (TW+1)'(T_DASH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t <= '0;
    end else if (state_next != state_reg) begin
      t <= '0;
    end else if (t != {TW{1'b1}}) begin
      t <= t + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sig_s) state_next = MARK;
      end
      MARK: begin
        if (!sig_s) begin
          if (mark_len < (TW+1)'(T_GLITCH)) begin
            state_next = (count == 3'd0) ? IDLE : SPACE;
          end else begin
            push       = 1'b1;
            state_next = SPACE;
          end
        end
      end
      SPACE: begin
        if (sig_s) begin
          state_next = MARK;
        end else if (t == TW'(T_LETTER - 1)) begin
          emit       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Symbol accumulator; a sixth element only flags the overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      count   <= '0;
      err_int <= 1'b0;
    end else if (emit) begin
      sr      <= '0;
      count   <= '0;
      err_int <= 1'b0;
    end else if (push) begin
      if (count == 3'(MAX_ELEMS)) begin
        err_int <= 1'b1;
      end else begin
        sr    <= {sr[3:0], push_bit};
        count <= count + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code  <= '0;
      len   <= '0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) begin
        code <= sr;
        len  <= count;
        err  <= err_int;
      end
    end
  end

endmodule

// File: doc/timed_pulse_decoder.md
TIMED_PULSE_DECODER -- requirements
Module: timed_pulse_decoder

Interface
REQ-001 SHALL have parameter T_GLITCH, default 4: marks shorter than this many cycles are discarded as noise.
REQ-002 SHALL have parameter T_DASH, default 60: minimum mark length, in cycles, classified as a dash.
REQ-003 SHALL have parameter T_LETTER, default 120: low length, in cycles, that ends a symbol.
REQ-004 SHALL have parameter TW, default 16: timer width, in bits.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port sig_in  in  1  asynchronous on/off-keyed pulse stream; 1 = mark.
REQ-008 SHALL have port code  out  5  decoded elements, LSB = most recent element; dot = 0, dash = 1.
REQ-009 SHALL have port len  out  3  number of valid elements in code, 0..5.
REQ-010 SHALL have port valid  out  1  one-cycle strobe qualifying code, len and err.
REQ-011 SHALL have port err  out  1  more than 5 elements were received in the symbol.

Function
REQ-012 SHALL pass sig_in through a 2-FF synchronizer to sig_s; all references below use sig_s.
REQ-013 SHALL implement a Mealy FSM with states IDLE, MARK and SPACE.
REQ-014 SHALL run a timer t that clears to 0 when state_next != state_reg, else increments, saturating at 2^TW-1.
REQ-015 IDLE: sig_s=1 -> MARK; otherwise stay in IDLE.
REQ-016 MARK: sig_s=0 with mark length L = t+1 -> classify: L<T_GLITCH discard; T_GLITCH<=L<T_DASH dot; L>=T_DASH dash.
REQ-017 MARK, discard: go to IDLE if the element count is 0, else go to SPACE with the space timer restarted.
REQ-018 MARK, dot or dash: shift into the shift register {sr[3:0],bit}, increment the count, go to SPACE.
REQ-019 An element arriving with count=5 SHALL leave sr and the count unchanged and set sticky err_int.
REQ-020 SPACE: sig_s=1 -> MARK; sig_s low for T_LETTER consecutive cycles (t = T_LETTER-1 with sig_s=0) -> emit and go to IDLE.
REQ-021 Emit SHALL register code=sr, len=count, err=err_int and valid=1 on the next edge, then clear sr, count and err_int.
REQ-022 valid SHALL be high for exactly one cycle per symbol; code, len and err SHALL hold until the next emit.
REQ-023 A mark exceeding the timer range SHALL be classified as a dash; saturation SHALL NOT wrap.
REQ-024 Total latency, from the sig_in falling edge that starts the terminating gap to valid, SHALL be T_LETTER+3 cycles.
REQ-025 T_GLITCH<T_DASH<T_LETTER<2^TW SHALL be required; violating values are unsupported.

Reset
REQ-026 reset=0 SHALL asynchronously force state IDLE, t=0, synchronizer FFs 0, sr=0, count=0, err_int=0.
REQ-027 reset=0 SHALL force the outputs code=0, len=0, valid=0, err=0.
REQ-028 Reset asserted mid-symbol SHALL discard the partial symbol; no valid SHALL follow reset release.

Structure
REQ-029 Shared package timed_decoder_pkg SHALL hold the state typedef (IDLE, MARK, SPACE) and the default T_* constants.
REQ-030 The synchronizer SHALL be sub-module sync_2ff (clk, reset, d, q), reusable elsewhere in the codebase.
REQ-031 The FSM, timer and output registers SHALL be in timed_pulse_decoder, in separate state, timer, next-state and output processes.

Verification (defaults T_GLITCH=4, T_DASH=60, T_LETTER=120)
REQ-032 Hold reset=0 with sig_in toggling -> valid=0, err=0, code=0, len=0 throughout.
REQ-033 Mark 20, gap 30, mark 80, gap 150 -> one valid, code=5'b00001, len=2, err=0.
REQ-034 Mark 59 and mark 60 as separate symbols, gaps 150 -> code=0, len=1 then code=1, len=1.
REQ-035 Isolated 3-cycle mark from IDLE -> no valid; mark 20, gap 119, mark 20, gap 150 -> single valid, len=2.
REQ-036 Six 20-cycle marks, 30-cycle gaps, then gap 150 -> valid with err=1, len=5, code=5'b00000.
REQ-037 reset=0 during the 2nd mark of a symbol, then release and idle 300 cycles -> no valid.
